// File: rtl/lb_dispatch_tree_if.sv
// rtl/lb_dispatch_tree_if.sv - request meta and dispatch decision handshakes of lb_dispatch_tree
interface lb_dispatch_tree_if #(
  parameter int HTTP_META_WIDTH = 98,
  parameter int N_REGIONS       = 4
);
  localparam int REGION_W = $clog2(N_REGIONS);

  logic                       meta_tvalid;
  logic                       meta_tready;
  logic [HTTP_META_WIDTH-1:0] meta_tdata;
  logic                       dec_valid;
  logic                       dec_ready;
  logic [REGION_W-1:0]        dec_region;
  logic [HTTP_META_WIDTH-1:0] dec_meta;
  logic                       dec_affinity;

  modport master (
    output meta_tvalid, meta_tdata, dec_ready,
    input  meta_tready, dec_valid, dec_region, dec_meta, dec_affinity
  );

  modport slave (
    input  meta_tvalid, meta_tdata, dec_ready,
    output meta_tready, dec_valid, dec_region, dec_meta, dec_affinity
  );
endinterface

// File: rtl/lb_dispatch_tree.sv
// rtl/lb_dispatch_tree.sv - least-load / affinity / round-robin request dispatcher with local in-flight tracking
module lb_dispatch_tree #(
  parameter int HTTP_META_WIDTH   = 98,
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int LOAD_BITS         = 4,
  parameter int INFLIGHT_BITS     = 4,
  parameter int N_REGIONS         = 4,
  parameter int MODE              = 0
) (
  input  logic                                               aclk,
  input  logic                                               aresetn,
  lb_dispatch_tree_if.slave                                  bus,
  input  logic [N_REGIONS*(OPERATOR_ID_WIDTH+LOAD_BITS)-1:0] region_stats_in,
  input  logic [N_REGIONS-1:0]                               region_en,
  input  logic [N_REGIONS-1:0]                               region_done
);
  localparam int RW      = $clog2(N_REGIONS);
  localparam int SW      = OPERATOR_ID_WIDTH + LOAD_BITS;
  localparam int EW      = LOAD_BITS + 1;
  localparam int LAYERS  = RW;
  localparam int EFF_MAX = (1 << EW) - 1;

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  typedef struct packed {
    logic          en;
    logic [EW-1:0] eff;
    logic          aff;
    logic [RW-1:0] rank;
    logic [RW-1:0] idx;
  } cand_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [RW-1:0]              rr_ptr;
  logic [INFLIGHT_BITS-1:0]   inflight   [N_REGIONS];
  logic [HTTP_META_WIDTH-1:0] meta_q;
  logic [SW-1:0]              snap_stats [N_REGIONS];
  logic [INFLIGHT_BITS-1:0]   snap_infl  [N_REGIONS];
  logic [N_REGIONS-1:0]       snap_en;
  logic [RW-1:0]              dec_region_q;
  logic                       dec_affinity_q;
  logic [N_REGIONS-1:0]       infl_inc;
  logic                       take_snapshot;
  logic                       commit;
  logic                       dec_fire;
  // Padded to 2*N so pair indices never leave the array; unused slots stay disabled.
  cand_t                      tree [LAYERS+1][2*N_REGIONS];

  // rank is the cyclic distance from rr_ptr, so a smaller rank wins the final tie-break.
  function automatic cand_t pick(input cand_t a, input cand_t b);
    logic b_wins;
    if (a.en != b.en)                       b_wins = b.en;
    else if (MODE == 0 && a.eff != b.eff)   b_wins = (b.eff < a.eff);
    else if (MODE == 0 && a.aff != b.aff)   b_wins = b.aff;
    else                                    b_wins = (b.rank < a.rank);
    return b_wins ? b : a;
  endfunction

  always_comb begin
    int cnt;
    int sum;
    cnt = N_REGIONS;
    sum = 0;
    for (int l = 0; l <= LAYERS; l++)
      for (int i = 0; i < 2*N_REGIONS; i++)
        tree[l][i] = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      sum = int'(snap_stats[r][LOAD_BITS-1:0]) + int'(snap_infl[r]);
      tree[0][r].en   = snap_en[r];
      tree[0][r].eff  = (sum > EFF_MAX) ? EW'(EFF_MAX) : EW'(sum);
      tree[0][r].aff  = (snap_stats[r][SW-1:LOAD_BITS] == meta_q[OPERATOR_ID_WIDTH-1:0]);
      tree[0][r].rank = RW'((r + N_REGIONS - int'(rr_ptr)) % N_REGIONS);
      tree[0][r].idx  = RW'(r);
    end
    for (int l = 0; l < LAYERS; l++) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (2*i + 1 < cnt)  tree[l+1][i] = pick(tree[l][2*i], tree[l][2*i+1]);
        else if (2*i < cnt) tree[l+1][i] = tree[l][2*i];
      end
      cnt = (cnt + 1) / 2;
    end
  end

  assign take_snapshot = (state == IDLE && bus.meta_tvalid) || (state == EVAL && !tree[LAYERS][0].en);
  assign commit        = (state == EVAL) && tree[LAYERS][0].en;
  assign dec_fire      = (state == OUT) && bus.dec_ready;

  always_comb begin
    state_nxt       = state;
    bus.meta_tready = 1'b0;
    bus.dec_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.meta_tready = aresetn;
        if (bus.meta_tvalid) state_nxt = EVAL;
      end
      EVAL: if (tree[LAYERS][0].en) state_nxt = OUT;
      OUT: begin
        bus.dec_valid = 1'b1;
        if (bus.dec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    infl_inc = '0;
    for (int r = 0; r < N_REGIONS; r++)
      infl_inc[r] = dec_fire && (dec_region_q == RW'(r));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      meta_q         <= '0;
      snap_en        <= '0;
      dec_region_q   <= '0;
      dec_affinity_q <= 1'b0;
      for (int r = 0; r < N_REGIONS; r++) begin
        inflight[r]   <= '0;
        snap_stats[r] <= '0;
        snap_infl[r]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.meta_tvalid) meta_q <= bus.meta_tdata;
      if (take_snapshot) begin
        snap_en <= region_en;
        for (int r = 0; r < N_REGIONS; r++) begin
          snap_stats[r] <= region_stats_in[r*SW +: SW];
          snap_infl[r]  <= inflight[r];
        end
      end
      if (commit) begin
        dec_region_q   <= tree[LAYERS][0].idx;
        dec_affinity_q <= tree[LAYERS][0].aff;
      end
      if (dec_fire)
        rr_ptr <= (dec_region_q == RW'(N_REGIONS - 1)) ? '0 : dec_region_q + 1'b1;
      // A dispatch and a retirement in the same cycle cancel out.
      for (int r = 0; r < N_REGIONS; r++) begin
        if (infl_inc[r] && !region_done[r] && inflight[r] != '1)
          inflight[r] <= inflight[r] + 1'b1;
        else if (region_done[r] && !infl_inc[r] && inflight[r] != '0)
          inflight[r] <= inflight[r] - 1'b1;
      end
    end
  end

  assign bus.dec_region   = dec_region_q;
  assign bus.dec_meta     = meta_q;
  assign bus.dec_affinity = dec_affinity_q;
endmodule

// File: tb/tb_lb_dispatch_tree.sv
// tb/tb_lb_dispatch_tree.sv - randomized self-checking bench for lb_dispatch_tree, MODE 0 and MODE 1 side by side
module tb_lb_dispatch_tree;
  localparam int W        = 98;
  localparam int OW       = 16;
  localparam int LB       = 4;
  localparam int IB       = 4;
  localparam int N        = 4;
  localparam int RW       = 2;
  localparam int SW       = OW + LB;
  localparam int INFL_MAX = 15;
  localparam int EFF_MAX  = 31;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          meta_tvalid;
  logic [W-1:0]  meta_tdata;
  logic          dec_ready;
  logic [N*SW-1:0] region_stats_in;
  logic [N-1:0]  region_en;
  logic [N-1:0]  region_done;

  always #5 aclk = ~aclk;

  lb_dispatch_tree_if #(.HTTP_META_WIDTH(W), .N_REGIONS(N)) bus0 ();
  lb_dispatch_tree_if #(.HTTP_META_WIDTH(W), .N_REGIONS(N)) bus1 ();

  assign bus0.meta_tvalid = meta_tvalid;
  assign bus0.meta_tdata  = meta_tdata;
  assign bus0.dec_ready   = dec_ready;
  assign bus1.meta_tvalid = meta_tvalid;
  assign bus1.meta_tdata  = meta_tdata;
  assign bus1.dec_ready   = dec_ready;

  lb_dispatch_tree #(.HTTP_META_WIDTH(W), .OPERATOR_ID_WIDTH(OW), .LOAD_BITS(LB),
                     .INFLIGHT_BITS(IB), .N_REGIONS(N), .MODE(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus0), .region_stats_in(region_stats_in),
    .region_en(region_en), .region_done(region_done));

  lb_dispatch_tree #(.HTTP_META_WIDTH(W), .OPERATOR_ID_WIDTH(OW), .LOAD_BITS(LB),
                     .INFLIGHT_BITS(IB), .N_REGIONS(N), .MODE(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1), .region_stats_in(region_stats_in),
    .region_en(region_en), .region_done(region_done));

  int checks = 0;
  int failures = 0;
  int m_infl [2][N];
  int m_rr [2];
  int s_infl [2][N];
  int s_load [N];
  int s_oid [N];
  logic [N-1:0] s_en;
  int cur_load [N];
  int cur_oid [N];
  int exp_region [2];
  bit exp_aff [2];
  logic [W-1:0] exp_meta;
  int obs_region [2];
  bit obs_aff [2];
  bit rnd_done = 1'b0;

  function automatic logic o_ready(input int m);
    return (m == 0) ? bus0.meta_tready : bus1.meta_tready;
  endfunction
  function automatic logic o_valid(input int m);
    return (m == 0) ? bus0.dec_valid : bus1.dec_valid;
  endfunction
  function automatic logic [RW-1:0] o_region(input int m);
    return (m == 0) ? bus0.dec_region : bus1.dec_region;
  endfunction
  function automatic logic o_aff(input int m);
    return (m == 0) ? bus0.dec_affinity : bus1.dec_affinity;
  endfunction
  function automatic logic [W-1:0] o_meta(input int m);
    return (m == 0) ? bus0.dec_meta : bus1.dec_meta;
  endfunction

  function automatic logic [W-1:0] rand_meta(input int oid);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    t[OW-1:0] = OW'(oid);
    return t[W-1:0];
  endfunction

  function automatic int eff_of(input int mode, input int r);
    int e;
    e = s_load[r] + s_infl[mode][r];
    return (e > EFF_MAX) ? EFF_MAX : e;
  endfunction

  // Reference choice: scan regions in cyclic order from rr_ptr and apply the rules in priority.
  function automatic int model_region(input int mode, input int req);
    int best_eff;
    int r;
    best_eff = EFF_MAX + 1;
    for (int k = 0; k < N; k++) begin
      r = (m_rr[mode] + k) % N;
      if (s_en[r] && mode == 1) return r;
      if (s_en[r] && eff_of(mode, r) < best_eff) best_eff = eff_of(mode, r);
    end
    for (int k = 0; k < N; k++) begin
      r = (m_rr[mode] + k) % N;
      if (s_en[r] && eff_of(mode, r) == best_eff && s_oid[r] == req) return r;
    end
    for (int k = 0; k < N; k++) begin
      r = (m_rr[mode] + k) % N;
      if (s_en[r] && eff_of(mode, r) == best_eff) return r;
    end
    return -1;
  endfunction

  task automatic apply_stats();
    for (int r = 0; r < N; r++) region_stats_in[r*SW +: SW] = {OW'(cur_oid[r]), LB'(cur_load[r])};
  endtask

  task automatic take_snapshot(input int req);
    s_en = region_en;
    for (int r = 0; r < N; r++) begin
      s_load[r] = cur_load[r];
      s_oid[r]  = cur_oid[r];
      for (int m = 0; m < 2; m++) s_infl[m][r] = m_infl[m][r];
    end
    for (int m = 0; m < 2; m++) begin
      exp_region[m] = model_region(m, req);
      exp_aff[m]    = (exp_region[m] >= 0) && (s_oid[(exp_region[m] < 0) ? 0 : exp_region[m]] == req);
    end
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      m_rr[m] = 0;
      for (int r = 0; r < N; r++) m_infl[m][r] = 0;
    end
  endtask

  task automatic tick(input bit hs, input logic [N-1:0] force_done);
    bit inc;
    bit dn;
    region_done = force_done;
    if (rnd_done) region_done = region_done | (N'($urandom) & N'($urandom) & N'($urandom));
    @(posedge aclk);
    if (aresetn) begin
      for (int m = 0; m < 2; m++) begin
        for (int r = 0; r < N; r++) begin
          inc = hs && (exp_region[m] == r);
          dn  = region_done[r];
          if (inc && !dn && m_infl[m][r] < INFL_MAX) m_infl[m][r]++;
          else if (dn && !inc && m_infl[m][r] > 0) m_infl[m][r]--;
        end
        if (hs) m_rr[m] = (exp_region[m] + 1) % N;
      end
    end
    #1;
    region_done = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    meta_tvalid = 1'b0;
    dec_ready = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    clear_model();
    aresetn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      if (o_ready(m) !== 1'b0) begin failures++; $display("FAIL %s_ready mode%0d got=%0b exp=0", tag, m, o_ready(m)); end
      checks++;
      if (o_valid(m) !== 1'b0) begin failures++; $display("FAIL %s_valid mode%0d got=%0b exp=0", tag, m, o_valid(m)); end
      checks++;
      if (o_region(m) !== '0) begin failures++; $display("FAIL %s_region mode%0d got=%0d exp=0", tag, m, o_region(m)); end
      checks++;
      if (o_meta(m) !== '0) begin failures++; $display("FAIL %s_meta mode%0d got=%h exp=0", tag, m, o_meta(m)); end
      checks++;
      if (o_aff(m) !== 1'b0) begin failures++; $display("FAIL %s_aff mode%0d got=%0b exp=0", tag, m, o_aff(m)); end
      checks++;
    end
  endtask

  task automatic run_request(input logic [W-1:0] meta, input int hold, input logic [N-1:0] hs_done);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (o_ready(m) !== 1'b1) begin failures++; $display("FAIL idle_ready mode%0d got=%0b exp=1", m, o_ready(m)); end
      checks++;
    end
    apply_stats();
    take_snapshot(int'(meta[OW-1:0]));
    exp_meta = meta;
    meta_tvalid = 1'b1;
    meta_tdata = meta;
    tick(1'b0, '0);
    meta_tvalid = 1'b0;
    meta_tdata = rand_meta(int'($urandom_range(0, 3)));
    for (int m = 0; m < 2; m++) begin
      if (o_valid(m) !== 1'b0 || o_ready(m) !== 1'b0) begin
        failures++; $display("FAIL eval_handshake mode%0d valid=%0b ready=%0b exp=0/0", m, o_valid(m), o_ready(m));
      end
      checks++;
    end
    tick(1'b0, '0);
    for (int k = 0; k <= hold; k++) begin
      if (k == hold) dec_ready = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (o_valid(m) !== 1'b1) begin failures++; $display("FAIL out_valid mode%0d got=%0b exp=1", m, o_valid(m)); end
        checks++;
        if (o_region(m) !== RW'(exp_region[m])) begin
          failures++; $display("FAIL dec_region mode%0d got=%0d exp=%0d", m, o_region(m), exp_region[m]);
        end
        checks++;
        if (o_aff(m) !== exp_aff[m]) begin failures++; $display("FAIL dec_affinity mode%0d got=%0b exp=%0b", m, o_aff(m), exp_aff[m]); end
        checks++;
        if (o_meta(m) !== exp_meta) begin failures++; $display("FAIL dec_meta mode%0d got=%h exp=%h", m, o_meta(m), exp_meta); end
        checks++;
        obs_region[m] = int'(o_region(m));
        obs_aff[m] = o_aff(m);
      end
      if (k < hold) region_en = N'($urandom);
      tick(k == hold, (k == hold) ? hs_done : '0);
    end
    dec_ready = 1'b0;
    region_en = s_en;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    meta_tvalid = 1'b1;
    dec_ready = 1'b0;
    tick(1'b0, '0);
    check_reset_outputs("reset");
    meta_tvalid = 1'b0;
    aresetn = 1'b1;
    clear_model();
  endtask

  task automatic test_spec_vectors();
    do_reset();
    cur_load = '{3, 1, 2, 1};
    cur_oid = '{7, 7, 7, 7};
    region_en = 4'b1111;
    run_request(rand_meta(5), 0, '0);
    if (obs_region[0] != 1 || obs_aff[0] != 1'b0) begin
      failures++; $display("FAIL least_load got=%0d/%0b exp=1/0", obs_region[0], obs_aff[0]);
    end
    checks++;
    do_reset();
    cur_load = '{0, 0, 0, 0};
    region_en = 4'b0010;
    run_request(rand_meta(0), 0, 4'b0010);
    cur_load = '{2, 2, 2, 2};
    cur_oid = '{0, 9, 9, 0};
    region_en = 4'b1111;
    run_request(rand_meta(9), 0, '0);
    if (obs_region[0] != 2 || obs_aff[0] != 1'b1) begin
      failures++; $display("FAIL affinity_tie got=%0d/%0b exp=2/1", obs_region[0], obs_aff[0]);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cur_load = '{0, 0, 0, 0};
    cur_oid = '{1, 2, 3, 4};
    region_en = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_request(rand_meta(0), 0, '0);
      if (obs_region[0] != i) begin failures++; $display("FAIL back_to_back[%0d] got=%0d exp=%0d", i, obs_region[0], i); end
      checks++;
    end
  endtask

  task automatic test_done_collision();
    do_reset();
    cur_load = '{1, 0, 0, 0};
    cur_oid = '{0, 0, 0, 0};
    region_en = 4'b0010;
    run_request(rand_meta(5), 0, 4'b0010);
    region_en = 4'b0011;
    run_request(rand_meta(5), 0, '0);
    if (obs_region[0] != 1) begin failures++; $display("FAIL done_collision got=%0d exp=1", obs_region[0]); end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    cur_load = '{0, 0, 0, 0};
    cur_oid = '{0, 0, 0, 0};
    region_en = 4'b0001;
    for (int i = 0; i < 17; i++) run_request(rand_meta(3), 0, '0);
    cur_load = '{0, 15, 0, 0};
    cur_oid = '{1, 2, 0, 0};
    region_en = 4'b0011;
    run_request(rand_meta(3), 0, '0);
    if (obs_region[0] != 1) begin failures++; $display("FAIL inflight_saturation got=%0d exp=1", obs_region[0]); end
    checks++;
  endtask

  task automatic test_no_enabled();
    do_reset();
    cur_load = '{0, 0, 0, 0};
    cur_oid = '{0, 0, 0, 0};
    region_en = 4'b0000;
    apply_stats();
    exp_meta = rand_meta(0);
    meta_tvalid = 1'b1;
    meta_tdata = exp_meta;
    tick(1'b0, '0);
    meta_tvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (o_valid(m) !== 1'b0) begin failures++; $display("FAIL no_enabled_hold[%0d] mode%0d got=%0b exp=0", c, m, o_valid(m)); end
        checks++;
      end
      tick(1'b0, '0);
    end
    region_en = 4'b0100;
    take_snapshot(0);
    tick(1'b0, '0);
    for (int m = 0; m < 2; m++) begin
      if (o_valid(m) !== 1'b0) begin failures++; $display("FAIL no_enabled_eval mode%0d got=%0b exp=0", m, o_valid(m)); end
      checks++;
    end
    tick(1'b0, '0);
    for (int m = 0; m < 2; m++) begin
      if (o_valid(m) !== 1'b1 || o_region(m) !== 2'd2) begin
        failures++; $display("FAIL no_enabled_release mode%0d valid=%0b region=%0d exp=1/2", m, o_valid(m), o_region(m));
      end
      checks++;
      if (o_meta(m) !== exp_meta) begin failures++; $display("FAIL no_enabled_meta mode%0d got=%h exp=%h", m, o_meta(m), exp_meta); end
      checks++;
    end
    dec_ready = 1'b1;
    tick(1'b1, '0);
    dec_ready = 1'b0;
  endtask

  task automatic test_mode1();
    int want [4];
    want = '{0, 1, 3, 0};
    do_reset();
    for (int r = 0; r < N; r++) begin
      cur_load[r] = int'($urandom_range(0, 15));
      cur_oid[r] = int'($urandom_range(0, 3));
    end
    region_en = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      run_request(rand_meta(int'($urandom_range(0, 3))), 0, '0);
      if (obs_region[1] != want[i]) begin failures++; $display("FAIL mode1_rr[%0d] got=%0d exp=%0d", i, obs_region[1], want[i]); end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cur_load = '{0, 0, 0, 0};
    cur_oid = '{1, 1, 1, 1};
    region_en = 4'b1111;
    apply_stats();
    meta_tvalid = 1'b1;
    meta_tdata = rand_meta(1);
    tick(1'b0, '0);
    meta_tvalid = 1'b0;
    tick(1'b0, '0);
    for (int m = 0; m < 2; m++) begin
      if (o_valid(m) !== 1'b1) begin failures++; $display("FAIL pre_reset_out mode%0d got=%0b exp=1", m, o_valid(m)); end
      checks++;
    end
    aresetn = 1'b0;
    tick(1'b0, '0);
    check_reset_outputs("reset_in_out");
    aresetn = 1'b1;
    clear_model();
    region_en = 4'b0000;
    meta_tvalid = 1'b1;
    tick(1'b0, '0);
    meta_tvalid = 1'b0;
    tick(1'b0, '0);
    aresetn = 1'b0;
    tick(1'b0, '0);
    check_reset_outputs("reset_in_eval");
    aresetn = 1'b1;
    clear_model();
    region_en = 4'b1111;
    run_request(rand_meta(2), 1, '0);
    if (obs_region[0] != 0 || obs_region[1] != 0) begin
      failures++; $display("FAIL post_reset_fresh got=%0d/%0d exp=0/0", obs_region[0], obs_region[1]);
    end
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    rnd_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < N; r++) begin
        cur_load[r] = (i % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
        cur_oid[r] = int'($urandom_range(0, 3));
      end
      region_en = N'($urandom_range(1, 15));
      run_request(rand_meta(int'($urandom_range(0, 3))), int'($urandom_range(0, 2)), '0);
    end
    rnd_done = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    meta_tvalid = 1'b0;
    meta_tdata = '0;
    dec_ready = 1'b0;
    region_stats_in = '0;
    region_en = '0;
    region_done = '0;
    clear_model();
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_done_collision();
    test_saturation();
    test_no_enabled();
    test_mode1();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
